// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: receiver for a toggle-encoded event line. It synchronises the line,
// turns each level change into a one-cycle pulse, counts events and buffers them for a valid/ready consumer.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              t_in,
  input  logic              ev_ready,
  input  logic              clr_ovf,
  output logic              q,
  output logic              q_bar,
  output logic              ev_pulse,
  output logic              ev_valid,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  ev_total,
  output logic              ovf,
  output logic              armed
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [2:0]        INIT_LAST = 3'(SYNC_STAGES);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t                 state;
  logic [2:0]             init_cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   t_prev;
  logic                   push;
  logic                   pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], t_in};
    end
  end

  assign q        = sync[SYNC_STAGES-1];
  assign q_bar    = ~q;
  assign ev_valid = (pend_cnt != '0);

  // INIT lets the synchroniser fill and t_prev track q so a high line at reset release is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      t_prev   <= 1'b0;
      ev_pulse <= 1'b0;
      armed    <= 1'b0;
    end else begin
      t_prev <= q;
      case (state)
        ST_INIT: begin
          ev_pulse <= 1'b0;
          if (init_cnt == INIT_LAST) begin
            state <= ST_RUN;
            armed <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 3'd1;
          end
        end
        default: begin
          ev_pulse <= q ^ t_prev;
        end
      endcase
    end
  end

  assign push = ev_pulse;
  assign pop  = ev_valid & ev_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
      ev_total <= '0;
      ovf      <= 1'b0;
    end else begin
      ev_total <= ev_total + {{(CNT_W-1){1'b0}}, push};
      if (push && !pop) begin
        if (pend_cnt != PEND_MAX) begin
          pend_cnt <= pend_cnt + {{(PEND_W-1){1'b0}}, 1'b1};
        end
      end else if (pop && !push) begin
        pend_cnt <= pend_cnt - {{(PEND_W-1){1'b0}}, 1'b1};
      end
      // A fresh drop outranks a simultaneous clear.
      if (push && !pop && (pend_cnt == PEND_MAX)) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: reset-release vector table, directed corner sequences and
// random traffic, all compared against an input-history model of the decoder.
module tb_toggle_event_decoder;

  localparam int S    = 2;
  localparam int PW   = 4;
  localparam int CW   = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          t_in;
  logic          ev_ready;
  logic          clr_ovf;
  logic          q;
  logic          q_bar;
  logic          ev_pulse;
  logic          ev_valid;
  logic [PW-1:0] pend_cnt;
  logic [CW-1:0] ev_total;
  logic          ovf;
  logic          armed;

  int checks   = 0;
  int failures = 0;

  toggle_event_decoder #(.SYNC_STAGES(S), .PEND_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .t_in(t_in), .ev_ready(ev_ready), .clr_ovf(clr_ovf),
    .q(q), .q_bar(q_bar), .ev_pulse(ev_pulse), .ev_valid(ev_valid), .pend_cnt(pend_cnt),
    .ev_total(ev_total), .ovf(ovf), .armed(armed)
  );

  always #5 clk = ~clk;

  // Model: remembers t_in as sampled at each edge since reset release.
  int hist [0:2047];
  int n;
  int m_pend, m_total, m_ovf, m_pulse, m_q, m_armed;

  function automatic int s_at(input int j);
    return (j < 1) ? 0 : hist[j];
  endfunction

  task automatic model_reset();
    n = 0; m_pend = 0; m_total = 0; m_ovf = 0; m_pulse = 0; m_q = 0; m_armed = 0;
  endtask

  task automatic model_edge(input logic t, input logic r, input logic c);
    int push, pop;
    push = m_pulse;
    pop  = (m_pend != 0 && r) ? 1 : 0;
    if (c) m_ovf = 0;
    if (push == 1 && pop == 0) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend = m_pend + 1;
    end else if (pop == 1 && push == 0) begin
      m_pend = m_pend - 1;
    end
    m_total = (m_total + push) % (1 << CW);
    n = n + 1;
    hist[n] = int'(t);
    m_q     = s_at(n - S + 1);
    m_armed = (n >= S + 1) ? 1 : 0;
    m_pulse = ((n - 1 >= S + 1) && (s_at(n - S) != s_at(n - S - 1))) ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("q", int'(q), m_q);
    chk("q_bar", int'(q_bar), 1 - m_q);
    chk("ev_pulse", int'(ev_pulse), m_pulse);
    chk("ev_valid", int'(ev_valid), (m_pend != 0) ? 1 : 0);
    chk("pend_cnt", int'(pend_cnt), m_pend);
    chk("ev_total", int'(ev_total), m_total);
    chk("ovf", int'(ovf), m_ovf);
    chk("armed", int'(armed), m_armed);
  endtask

  // Called at a falling edge: apply inputs, take one rising edge, compare at the next falling edge.
  task automatic step(input logic t, input logic r, input logic c);
    t_in = t; ev_ready = r; clr_ovf = c;
    @(posedge clk);
    model_edge(t, r, c);
    @(negedge clk);
    check_model();
  endtask

  // Asserts reset between edges, checks the immediate clear, releases on a falling edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_q_bar", int'(q_bar), 1);
    chk("rst_pulse", int'(ev_pulse), 0);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_pend", int'(pend_cnt), 0);
    chk("rst_total", int'(ev_total), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_armed", int'(armed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       t;
    logic       ready;
    logic [3:0] pend;
    logic       pulse;
    logic       q;
    logic       armed;
    logic [7:0] total;
  } vec_t;

  vec_t tbl [14];
  int   drain_exp [5] = '{2, 1, 0, 0, 0};
  logic tt;

  initial begin
    // Edges 1..10: t_in high from release; edges 11..14: one toggle to 0.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 1'b0, 4'd0, 1'b0, (i >= 1), (i >= 2), 8'd0};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 8'd1};

    rst_n = 1'b0; t_in = 1'b1; ev_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].t, tbl[i].ready, 1'b0);
      chk("tbl_pend", int'(pend_cnt), int'(tbl[i].pend));
      chk("tbl_pulse", int'(ev_pulse), int'(tbl[i].pulse));
      chk("tbl_q", int'(q), int'(tbl[i].q));
      chk("tbl_armed", int'(armed), int'(tbl[i].armed));
      chk("tbl_total", int'(ev_total), int'(tbl[i].total));
    end

    // Saturation: 16 toggles two cycles apart with no consumer.
    async_reset();
    tt = 1'b0;
    for (int i = 0; i < 4; i++) step(tt, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tt = ~tt;
      step(tt, 1'b0, 1'b0);
      step(tt, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(tt, 1'b0, 1'b0);
    chk("sat_pend", int'(pend_cnt), 15);
    chk("sat_ovf", int'(ovf), 1);
    chk("sat_total", int'(ev_total), 16);
    step(tt, 1'b0, 1'b1);
    chk("clr_ovf", int'(ovf), 0);

    // Full buffer: pulse coincides with an accept.
    tt = ~tt;
    for (int i = 0; i < 3; i++) step(tt, 1'b0, 1'b0);
    chk("full_pulse", int'(ev_pulse), 1);
    step(tt, 1'b1, 1'b0);
    chk("full_pp_pend", int'(pend_cnt), 15);
    chk("full_pp_ovf", int'(ovf), 0);

    // Drain to 3, then hold ready past empty.
    for (int i = 0; i < 12; i++) step(tt, 1'b1, 1'b0);
    chk("drain3", int'(pend_cnt), 3);
    for (int i = 0; i < 5; i++) begin
      step(tt, 1'b1, 1'b0);
      chk("drain_pend", int'(pend_cnt), drain_exp[i]);
    end
    chk("drain_valid", int'(ev_valid), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tt = ~tt;
      step(tt, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of activity with pend=5, total=7.
    async_reset();
    tt = 1'b0;
    for (int i = 0; i < 4; i++) step(tt, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tt = ~tt;
      step(tt, 1'b0, 1'b0);
      step(tt, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(tt, 1'b0, 1'b0);
    step(tt, 1'b1, 1'b0);
    step(tt, 1'b1, 1'b0);
    chk("pre_rst_pend", int'(pend_cnt), 5);
    chk("pre_rst_total", int'(ev_total), 7);
    async_reset();
    tt = ~tt;
    step(tt, 1'b0, 1'b0);
    chk("reinit_armed", int'(armed), 0);
    for (int i = 0; i < 10; i++) begin
      step(tt, 1'b0, 1'b0);
      chk("reinit_nopulse", int'(ev_pulse), 0);
    end
    chk("reinit_total", int'(ev_total), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receiver end of a toggle-encoded event link. The sender is a T latch/flip-flop with t tied high per event, so every event flips one level line.
- This block synchronises that level, converts each level change back into a one-cycle event pulse, and counts events.
- Unconsumed events are buffered in a saturating pending counter and drained through a valid/ready handshake.
- It sits at the consumer side of any toggle-signalled path: interrupt lines, cross-block strobes, slow control links.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchroniser chain (legal range 2..4).
- PEND_W, 4, width of the pending-event counter; saturates at 2^PEND_W-1.
- CNT_W, 8, width of the free-running total-event counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- t_in  input  1  toggle-encoded level line from the sender (may be asynchronous to clk).
- ev_ready  input  1  consumer accepts one buffered event this cycle.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- q  output  1  synchronised level of t_in.
- q_bar  output  1  complement of q.
- ev_pulse  output  1  one-cycle pulse per detected toggle.
- ev_valid  output  1  at least one event pending.
- pend_cnt  output  PEND_W  number of pending events.
- ev_total  output  CNT_W  total events detected since reset, wraps.
- ovf  output  1  sticky: an event was dropped because the buffer was full.
- armed  output  1  high once the INIT phase is complete.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser chain, t_prev, ev_pulse, pend_cnt, ev_total, ovf and armed all go to 0.
  - q=0, q_bar=1.
  - FSM enters INIT.
  - Reset asserted mid-operation discards all pending events immediately.
- Synchroniser: t_in passes through SYNC_STAGES flops. q is the last stage; q_bar = ~q at all times.
- FSM:
  - INIT: counts SYNC_STAGES+1 cycles after reset release.
    - Each cycle, t_prev <= q. No toggles are detected.
    - A high t_in at reset release therefore causes no spurious event.
    - On the final INIT cycle, go to RUN and set armed=1.
  - RUN: toggle = q ^ t_prev; t_prev <= q every cycle.
  - RUN is left only by reset.
- Event detect latency:
  - Assume t_in changes and is stable before rising edge k.
  - ev_pulse is registered and is high for exactly one cycle, after edge k+SYNC_STAGES.
  - With SYNC_STAGES=2, ev_pulse is high in the cycle following the 3rd edge.
- Toggle rate: back-to-back toggles one cycle apart each produce a separate ev_pulse. Minimum stable input time is 1 clk period; faster changes are not guaranteed.
- ev_total increments by 1 on every ev_pulse and wraps 2^CNT_W-1 -> 0.
- Pending counter, evaluated with push = ev_pulse and pop = ev_valid & ev_ready:
  - push only: increment, unless pend_cnt = 2^PEND_W-1. In that case pend_cnt holds and ovf <= 1.
  - pop only: decrement.
  - push and pop together: pend_cnt unchanged, no overflow, including when full.
  - ev_ready while pend_cnt = 0: ignored, no underflow.
- ev_valid = (pend_cnt != 0), combinational from the register.
- ovf:
  - Sticky; cleared only by clr_ovf or reset.
  - If clr_ovf and a new overflow occur in the same cycle, set wins (ovf stays 1).
- ev_total counts dropped events as well, so that ev_total minus the number of handshakes minus pend_cnt equals the number of dropped events (modulo 2^CNT_W).

Test Plan:
- Reset release with t_in=1, held for 10 cycles -> armed rises after 3 cycles (SYNC_STAGES=2); ev_pulse never asserts; q=1, q_bar=0; ev_total=0.
- Armed, ev_ready=0, toggle t_in 0->1 once -> ev_pulse high for exactly one cycle, after the 3rd edge following the change; pend_cnt=1, ev_valid=1, ev_total=1.
- Armed, ev_ready=0, 16 toggles spaced 2 cycles apart -> pend_cnt saturates at 15; ovf=1 after the 16th; ev_total=16. Then pulse clr_ovf -> ovf=0.
- pend_cnt=15, toggle arrives in the same cycle as ev_ready=1 -> pend_cnt stays 15, ovf stays 0.
- pend_cnt=3, hold ev_ready=1 for 5 cycles -> pend_cnt 2, 1, 0, then stays 0; ev_valid drops after the 3rd accept; no underflow.
- pend_cnt=5, ev_total=7, assert rst_n=0 asynchronously between clock edges -> all outputs clear immediately; after release, INIT repeats before any event is detected.
